ysyx_23060236_lsu: RTL and testbench

Load/store stage between the execute stage and write-back. Takes the execute result (address or ALU value, store data, destination register) and, for loads and stores, runs one AXI4-Lite transaction on the data bus with byte-lane alignment and sign or zero extension. Non-memory instructions pass straight through. The block always forwards a write-back record to the WBU.

---
 rtl/ysyx_23060236_lsu_pkg.sv | 33 +++
 rtl/ysyx_23060236_lsu_align.sv | 34 +++
 rtl/ysyx_23060236_lsu.sv | 179 +++++++++++++++++
 tb/tb_ysyx_23060236_lsu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060236_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, AXI response codes, FSM states.
package ysyx_23060236_lsu_pkg;

  // funct3 access-size encodings
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_DONE    = 3'd5
  } lsu_state_e;

  // Unshifted byte-strobe pattern for a store; unused codes behave as a word store.
  function automatic logic [3:0] store_mask(input logic [2:0] f3);
    logic [3:0] m;
    case (f3)
      LSU_B:   m = 4'b0001;
      LSU_H:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_23060236_lsu_align.sv
// Byte-lane alignment: store strobe/data shift and load shift plus sign/zero extension.
module ysyx_23060236_lsu_align
  import ysyx_23060236_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] read_word_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_val_o
);

  logic [4:0]  shamt;
  logic [31:0] rshift;

  assign shamt   = {addr_lo_i, 3'b000};
  assign wstrb_o = store_mask(funct3_i) << addr_lo_i;
  assign wdata_o = store_data_i << shamt;
  assign rshift  = read_word_i >> shamt;

  // Extend the lane selected by the address; unused codes return the shifted word.
  always_comb begin
    load_val_o = rshift;
    case (funct3_i)
      LSU_B:   load_val_o = {{24{rshift[7]}}, rshift[7:0]};
      LSU_H:   load_val_o = {{16{rshift[15]}}, rshift[15:0]};
      LSU_BU:  load_val_o = {24'h0, rshift[7:0]};
      LSU_HU:  load_val_o = {16'h0, rshift[15:0]};
      default: load_val_o = rshift;
    endcase
  end

endmodule

// File: rtl/ysyx_23060236_lsu.sv
// Load/store stage: one AXI4-Lite access per load/store, pass-through otherwise,
// always hands a write-back record to the WBU.
//
// state     | meaning
// IDLE      | ready for a request from EXU
// RD_ADDR   | read address offered on AR
// RD_DATA   | waiting for read data on R
// WR_REQ    | AW and W offered, each retires on its own handshake
// WR_RESP   | waiting for write response on B
// DONE      | write-back record held for the WBU
module ysyx_23060236_lsu
  import ysyx_23060236_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic              lsu_ren,
  input  logic              lsu_wen,
  input  logic [31:0]       val,
  input  logic [31:0]       wdata_in,
  input  logic [2:0]        funct3,
  input  logic [3:0]        rd,
  input  logic              reg_wen,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              wbu_valid,
  input  logic              wbu_ready,
  output logic [3:0]        wb_rd,
  output logic              wb_wen,
  output logic [31:0]       wb_val,
  output logic              access_err
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [31:0]       wb_val_q, wb_val_d;
  logic [3:0]        wb_rd_q, wb_rd_d;
  logic              wb_wen_q, wb_wen_d;
  logic              err_q, err_d;
  logic [31:0]       load_val;

  ysyx_23060236_lsu_align u_align (
    .addr_lo_i    (addr_q[1:0]),
    .funct3_i     (funct3_q),
    .store_data_i (sdata_q),
    .read_word_i  (rdata),
    .wstrb_o      (wstrb),
    .wdata_o      (wdata),
    .load_val_o   (load_val)
  );

  assign araddr     = {addr_q[ADDR_W-1:2], 2'b00};
  assign awaddr     = {addr_q[ADDR_W-1:2], 2'b00};
  assign wb_rd      = wb_rd_q;
  assign wb_wen     = wb_wen_q;
  assign wb_val     = wb_val_q;
  assign access_err = err_q;

  // Next-state, handshake outputs and register updates per state.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    funct3_d  = funct3_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wb_val_d  = wb_val_q;
    wb_rd_d   = wb_rd_q;
    wb_wen_d  = wb_wen_q;
    err_d     = err_q;
    lsu_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    wbu_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        lsu_ready = 1'b1;
        if (lsu_valid) begin
          addr_d    = val[ADDR_W-1:0];
          sdata_d   = wdata_in;
          funct3_d  = funct3;
          wb_rd_d   = rd;
          wb_wen_d  = reg_wen & ~lsu_wen;
          wb_val_d  = val;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (lsu_ren)      state_d = S_RD_ADDR;
          else if (lsu_wen) state_d = S_WR_REQ;
          else              state_d = S_DONE;
        end
      end
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          wb_val_d = load_val;
          err_d    = (rresp != AXI_OKAY);
          state_d  = S_DONE;
        end
      end
      S_WR_REQ: begin
        awvalid   = ~aw_done_q;
        wvalid    = ~w_done_q;
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          err_d   = (bresp != AXI_OKAY);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        wbu_valid = 1'b1;
        if (wbu_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      sdata_q   <= '0;
      funct3_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wb_val_q  <= '0;
      wb_rd_q   <= '0;
      wb_wen_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      funct3_q  <= funct3_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wb_val_q  <= wb_val_d;
      wb_rd_q   <= wb_rd_d;
      wb_wen_q  <= wb_wen_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_lsu.sv
// Directed bench for the load/store unit; inputs driven and outputs sampled on the falling edge.
module tb_ysyx_23060236_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        lsu_valid, lsu_ready, lsu_ren, lsu_wen;
  logic [31:0] val, wdata_in;
  logic [2:0]  funct3;
  logic [3:0]  rd;
  logic        reg_wen;
  logic [31:0] araddr, awaddr;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready, bvalid, bready;
  logic        wbu_valid, wbu_ready;
  logic [3:0]  wb_rd;
  logic        wb_wen;
  logic [31:0] wb_val;
  logic        access_err;

  int checks = 0;
  int errors = 0;
  int aw_hs  = 0;
  int w_hs   = 0;

  ysyx_23060236_lsu #(.ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_ren(lsu_ren), .lsu_wen(lsu_wen),
    .val(val), .wdata_in(wdata_in), .funct3(funct3), .rd(rd), .reg_wen(reg_wen),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .wbu_valid(wbu_valid), .wbu_ready(wbu_ready),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_val(wb_val), .access_err(access_err)
  );

  always #5 clock = ~clock;

  // Count completed AW and W handshakes.
  always @(posedge clock) begin
    if (awvalid && awready) aw_hs++;
    if (wvalid && wready) w_hs++;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic ren, input logic wen, input logic [31:0] v,
                       input logic [31:0] wd, input logic [2:0] f3, input logic [3:0] rdv);
    lsu_valid = 1'b1; lsu_ren = ren; lsu_wen = wen;
    val = v; wdata_in = wd; funct3 = f3; rd = rdv; reg_wen = 1'b1;
    @(negedge clock);
    lsu_valid = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0;
  endtask

  task automatic release_wbu(input string tag);
    wbu_ready = 1'b1;
    @(negedge clock);
    wbu_ready = 1'b0;
    chk({tag, "_idle_wbu_valid"}, {31'h0, wbu_valid}, 32'h0);
    chk({tag, "_idle_lsu_ready"}, {31'h0, lsu_ready}, 32'h1);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rword, input logic [1:0] resp,
                         input logic [31:0] exp_val, input logic exp_err, input int hold);
    issue(1'b1, 1'b0, addr, 32'h0, f3, 4'd7);
    chk({tag, "_arvalid"}, {31'h0, arvalid}, 32'h1);
    chk({tag, "_araddr"}, araddr, addr & 32'hFFFF_FFFC);
    chk({tag, "_rready_early"}, {31'h0, rready}, 32'h0);
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    chk({tag, "_arvalid_drop"}, {31'h0, arvalid}, 32'h0);
    chk({tag, "_rready"}, {31'h0, rready}, 32'h1);
    rvalid = 1'b1; rdata = rword; rresp = resp;
    @(negedge clock);
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    chk({tag, "_wbu_valid"}, {31'h0, wbu_valid}, 32'h1);
    chk({tag, "_wb_val"}, wb_val, exp_val);
    chk({tag, "_err"}, {31'h0, access_err}, {31'h0, exp_err});
    chk({tag, "_wb_rd"}, {28'h0, wb_rd}, 32'h7);
    chk({tag, "_wb_wen"}, {31'h0, wb_wen}, 32'h1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk({tag, "_hold_valid"}, {31'h0, wbu_valid}, 32'h1);
      chk({tag, "_hold_val"}, wb_val, exp_val);
      chk({tag, "_hold_err"}, {31'h0, access_err}, {31'h0, exp_err});
    end
    release_wbu(tag);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input int aw_dly, input int w_dly,
                          input logic [1:0] resp, input logic exp_err);
    int aw0, w0, last;
    aw0 = aw_hs; w0 = w_hs;
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    issue(1'b0, 1'b1, addr, wd, f3, 4'd9);
    for (int k = 0; k <= last; k++) begin
      chk({tag, "_awvalid"}, {31'h0, awvalid}, {31'h0, (k <= aw_dly)});
      chk({tag, "_wvalid"}, {31'h0, wvalid}, {31'h0, (k <= w_dly)});
      chk({tag, "_awaddr"}, awaddr, addr & 32'hFFFF_FFFC);
      chk({tag, "_wstrb"}, {28'h0, wstrb}, {28'h0, exp_strb});
      chk({tag, "_wdata"}, wdata, exp_wdata);
      chk({tag, "_bready_early"}, {31'h0, bready}, 32'h0);
      awready = (k >= aw_dly);
      wready  = (k >= w_dly);
      @(negedge clock);
    end
    awready = 1'b0; wready = 1'b0;
    chk({tag, "_awvalid_drop"}, {31'h0, awvalid}, 32'h0);
    chk({tag, "_wvalid_drop"}, {31'h0, wvalid}, 32'h0);
    chk({tag, "_bready"}, {31'h0, bready}, 32'h1);
    bvalid = 1'b1; bresp = resp;
    @(negedge clock);
    bvalid = 1'b0; bresp = 2'b00;
    chk({tag, "_wbu_valid"}, {31'h0, wbu_valid}, 32'h1);
    chk({tag, "_wb_wen"}, {31'h0, wb_wen}, 32'h0);
    chk({tag, "_err"}, {31'h0, access_err}, {31'h0, exp_err});
    chk({tag, "_aw_count"}, aw_hs - aw0, 32'd1);
    chk({tag, "_w_count"}, w_hs - w0, 32'd1);
    release_wbu(tag);
  endtask

  initial begin
    reset = 1'b1;
    lsu_valid = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0;
    val = 32'h0; wdata_in = 32'h0; funct3 = 3'b000; rd = 4'h0; reg_wen = 1'b0;
    arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    wbu_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // reset state
    chk("rst_lsu_ready", {31'h0, lsu_ready}, 32'h1);
    chk("rst_wbu_valid", {31'h0, wbu_valid}, 32'h0);
    chk("rst_arvalid", {31'h0, arvalid}, 32'h0);
    chk("rst_rready", {31'h0, rready}, 32'h0);
    chk("rst_awvalid", {31'h0, awvalid}, 32'h0);
    chk("rst_wvalid", {31'h0, wvalid}, 32'h0);
    chk("rst_bready", {31'h0, bready}, 32'h0);
    chk("rst_wb_val", wb_val, 32'h0);
    chk("rst_wb_rd", {28'h0, wb_rd}, 32'h0);
    chk("rst_wb_wen", {31'h0, wb_wen}, 32'h0);
    chk("rst_err", {31'h0, access_err}, 32'h0);

    // pass-through: result at cycle 1
    lsu_valid = 1'b1; val = 32'h0000_1234; rd = 4'd5; reg_wen = 1'b1; funct3 = 3'b010;
    @(negedge clock);
    lsu_valid = 1'b0;
    chk("pt_wbu_valid", {31'h0, wbu_valid}, 32'h1);
    chk("pt_wb_val", wb_val, 32'h0000_1234);
    chk("pt_wb_rd", {28'h0, wb_rd}, 32'h5);
    chk("pt_wb_wen", {31'h0, wb_wen}, 32'h1);
    chk("pt_lsu_ready", {31'h0, lsu_ready}, 32'h0);
    chk("pt_arvalid", {31'h0, arvalid}, 32'h0);
    release_wbu("pt");

    // loads: byte/half sign and zero extension, word, unused funct3
    do_load("lb",  32'h8000_0003, 3'b000, 32'h80FF_FFFF, 2'b00, 32'hFFFF_FF80, 1'b0, 0);
    do_load("lbu", 32'h8000_0003, 3'b100, 32'h80FF_FFFF, 2'b00, 32'h0000_0080, 1'b0, 0);
    do_load("lh",  32'h8000_0002, 3'b001, 32'h8001_1234, 2'b00, 32'hFFFF_8001, 1'b0, 0);
    do_load("lhu", 32'h8000_0002, 3'b101, 32'h8001_1234, 2'b00, 32'h0000_8001, 1'b0, 0);
    do_load("lb1", 32'h8000_0001, 3'b000, 32'h1122_7F44, 2'b00, 32'h0000_007F, 1'b0, 0);
    do_load("lw_u3", 32'h8000_0000, 3'b011, 32'h89AB_CDEF, 2'b00, 32'h89AB_CDEF, 1'b0, 0);

    // load with SLVERR and WBU stalled 3 cycles
    do_load("lw_err", 32'h8000_0004, 3'b010, 32'hDEAD_BEEF, 2'b10, 32'hDEAD_BEEF, 1'b1, 3);

    // stores: sh with AW two cycles ahead of W, sb with simultaneous handshakes, sw with error
    do_store("sh", 32'h8000_0002, 3'b001, 32'h0000_BEEF, 4'b1100, 32'hBEEF_0000, 0, 2, 2'b00, 1'b0);
    do_store("sb", 32'h8000_0001, 3'b000, 32'h1234_56A5, 4'b0010, 32'h3456_A500, 1, 1, 2'b00, 1'b0);
    do_store("sw", 32'h8000_0010, 3'b010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 0, 0, 2'b10, 1'b1);
    do_store("sw_w_first", 32'h8000_0020, 3'b010, 32'h0BAD_CAFE, 4'b1111, 32'h0BAD_CAFE, 2, 0, 2'b00, 1'b0);

    // reset while in RD_DATA aborts the load
    issue(1'b1, 1'b0, 32'h8000_0008, 32'h0, 3'b010, 4'd7);
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    chk("mid_rready", {31'h0, rready}, 32'h1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_arvalid", {31'h0, arvalid}, 32'h0);
    chk("mid_rready_drop", {31'h0, rready}, 32'h0);
    chk("mid_awvalid", {31'h0, awvalid}, 32'h0);
    chk("mid_wvalid", {31'h0, wvalid}, 32'h0);
    chk("mid_bready", {31'h0, bready}, 32'h0);
    chk("mid_wbu_valid", {31'h0, wbu_valid}, 32'h0);
    chk("mid_lsu_ready", {31'h0, lsu_ready}, 32'h1);
    do_load("lw_after_rst", 32'h8000_0008, 3'b010, 32'h1357_9BDF, 2'b00, 32'h1357_9BDF, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
